// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: shared definitions for the Wishbone timer block.
// Holds the register offsets inside the 256-byte window, the CTRL bit
// indices, the bus FSM state type and a byte-lane merge helper.
// Optional feature macro used by the top: TIMER_LA_OVERRIDE_EN.
package wb_timer_pkg;

   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_PRESCALE = 8'h04;
   localparam logic [7:0] OFF_COUNT    = 8'h08;
   localparam logic [7:0] OFF_COMPARE  = 8'h0C;
   localparam logic [7:0] OFF_STATUS   = 8'h10;

   localparam int CTRL_ENABLE     = 0;
   localparam int CTRL_IRQ_EN     = 1;
   localparam int CTRL_AUTORELOAD = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } bus_state_t;

   // Replace only the byte lanes whose select bit is set.
   function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_timer_irq_if.sv
// wb_timer_irq_if: Wishbone slave bus bundle for the timer.
//   cyc/stb/we/sel/adr/dat_w : master -> slave request
//   ack/dat_r                : slave -> master response
interface wb_timer_irq_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic        ack;
   logic [31:0] dat_r;

   modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
   modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/wb_timer_bus_if.sv
// wb_timer_bus_if: address decode and two-state acknowledge FSM.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   bus                : Wishbone slave modport
//   o_wr_en            : one-cycle register write strobe (request cycle)
//   o_offset           : byte offset inside the window
//   o_wr_data/o_wr_sel : write data and byte enables
//   i_rd_data          : read data for o_offset, captured with the ack
module wb_timer_bus_if
   import wb_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   wb_timer_irq_if.slave bus,
   output logic        o_wr_en,
   output logic [7:0]  o_offset,
   output logic [31:0] o_wr_data,
   output logic [3:0]  o_wr_sel,
   input  logic [31:0] i_rd_data
);

   bus_state_t  r_state;
   logic        r_ack;
   logic [31:0] r_dat;
   logic        w_hit;

   assign w_hit     = bus.cyc & bus.stb & (bus.adr[31:8] == BASE_ADDR[31:8]);
   assign o_offset  = bus.adr[7:0];
   assign o_wr_data = bus.dat_w;
   assign o_wr_sel  = bus.sel;
   // Writes commit on the request cycle, so they become visible together
   // with the ack. A request still held during ACK is not re-executed.
   assign o_wr_en   = w_hit & bus.we & (r_state == ST_IDLE);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_ack   <= 1'b0;
         r_dat   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hit) begin
                  r_state <= ST_ACK;
                  r_ack   <= 1'b1;
                  r_dat   <= bus.we ? 32'd0 : i_rd_data;
               end else begin
                  r_ack <= 1'b0;
                  r_dat <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ack   <= 1'b0;
               r_dat   <= '0;
            end
         endcase
      end
   end

   assign bus.ack   = r_ack;
   assign bus.dat_r = r_dat;

endmodule

// File: rtl/wb_timer_irq.sv
// wb_timer_irq: Wishbone-mapped prescaled 32-bit timer with compare match
// interrupt. Registers: CTRL {autoreload, irq_en, enable}, PRESCALE,
// COUNT, COMPARE, STATUS (match, write-1-to-clear).
// Ports:
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   wbs_*                       : Wishbone slave bus
//   la_data_in, la_oenb         : logic analyzer inputs (override only)
//   irq[2:0]                    : irq[0] = match & irq_en, others 0
// Optional macro TIMER_LA_OVERRIDE_EN: la_oenb[0]==0 makes la_data_in[0]
// the enable; la_oenb[1]==0 with la_data_in[1]==1 holds prescaler and
// COUNT at zero.
module wb_timer_irq
   import wb_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          PRESCALE_W = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic [63:0] la_data_in,
   input  logic [63:0] la_oenb,
   output logic [2:0]  irq
);

   // PRESCALE is kept 32 bits wide with unused bits masked to zero, which
   // keeps readback and byte-lane writes uniform for any PRESCALE_W.
   localparam logic [31:0] PRESCALE_MASK = (PRESCALE_W >= 32) ? 32'hFFFF_FFFF
                                         : ((32'd1 << PRESCALE_W) - 32'd1);
   localparam logic [31:0] CTRL_MASK = 32'h0000_0007;

   wb_timer_irq_if u_bus_if ();

   assign u_bus_if.cyc   = wbs_cyc_i;
   assign u_bus_if.stb   = wbs_stb_i;
   assign u_bus_if.we    = wbs_we_i;
   assign u_bus_if.sel   = wbs_sel_i;
   assign u_bus_if.adr   = wbs_adr_i;
   assign u_bus_if.dat_w = wbs_dat_i;
   assign wbs_ack_o      = u_bus_if.ack;
   assign wbs_dat_o      = u_bus_if.dat_r;

   logic                  w_wr_en;
   logic [7:0]            w_offset;
   logic [31:0]           w_wr_data;
   logic [3:0]            w_wr_sel;
   logic [31:0]           w_rd_data;

   wb_timer_bus_if #(.BASE_ADDR(BASE_ADDR)) u_bus (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .bus       (u_bus_if),
      .o_wr_en   (w_wr_en),
      .o_offset  (w_offset),
      .o_wr_data (w_wr_data),
      .o_wr_sel  (w_wr_sel),
      .i_rd_data (w_rd_data)
   );

   logic [31:0]           r_ctrl;
   logic [31:0]           r_prescale;
   logic [31:0]           r_count;
   logic [31:0]           r_compare;
   logic                  r_status;
   logic [PRESCALE_W-1:0] r_pre_cnt;

   logic w_enable, w_la_clear, w_la_unused;
   logic w_tick, w_match;
   logic w_wr_ctrl, w_wr_pre, w_wr_count, w_wr_cmp, w_clr_status;

`ifdef TIMER_LA_OVERRIDE_EN
   assign w_enable    = la_oenb[0] ? r_ctrl[CTRL_ENABLE] : la_data_in[0];
   assign w_la_clear  = ~la_oenb[1] & la_data_in[1];
   assign w_la_unused = ^{la_data_in[63:2], la_oenb[63:2]};
`else
   assign w_enable    = r_ctrl[CTRL_ENABLE];
   assign w_la_clear  = 1'b0;
   assign w_la_unused = ^{la_data_in, la_oenb};
`endif

   assign w_wr_ctrl    = w_wr_en && (w_offset == OFF_CTRL);
   assign w_wr_pre     = w_wr_en && (w_offset == OFF_PRESCALE);
   assign w_wr_count   = w_wr_en && (w_offset == OFF_COUNT);
   assign w_wr_cmp     = w_wr_en && (w_offset == OFF_COMPARE);
   assign w_clr_status = w_wr_en && (w_offset == OFF_STATUS) && w_wr_sel[0] && w_wr_data[0];

   assign w_tick  = w_enable && !w_la_clear && (r_pre_cnt == r_prescale[PRESCALE_W-1:0]);
   assign w_match = w_tick && (r_count == r_compare);

   always_comb begin
      w_rd_data = '0;
      case (w_offset)
         OFF_CTRL:     w_rd_data = r_ctrl;
         OFF_PRESCALE: w_rd_data = r_prescale;
         OFF_COUNT:    w_rd_data = r_count;
         OFF_COMPARE:  w_rd_data = r_compare;
         OFF_STATUS:   w_rd_data = {31'd0, r_status};
         default:      w_rd_data = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ctrl     <= '0;
         r_prescale <= '0;
         r_count    <= '0;
         r_compare  <= '0;
         r_status   <= 1'b0;
         r_pre_cnt  <= '0;
      end else begin
         if (w_wr_ctrl) r_ctrl <= apply_sel(r_ctrl, w_wr_data, w_wr_sel) & CTRL_MASK;
         if (w_wr_cmp)  r_compare <= apply_sel(r_compare, w_wr_data, w_wr_sel);
         if (w_wr_pre)  r_prescale <= apply_sel(r_prescale, w_wr_data, w_wr_sel) & PRESCALE_MASK;

         if (w_la_clear || w_wr_pre || w_tick) r_pre_cnt <= '0;
         else if (w_enable)                    r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);

         // Bus write beats the tick; the LA clear beats everything.
         if (w_la_clear)      r_count <= '0;
         else if (w_wr_count) r_count <= apply_sel(r_count, w_wr_data, w_wr_sel);
         else if (w_tick)     r_count <= (w_match && r_ctrl[CTRL_AUTORELOAD]) ? 32'd0
                                                                           : r_count + 32'd1;

         // A fresh match wins over a simultaneous write-1-to-clear.
         if (w_match)           r_status <= 1'b1;
         else if (w_clr_status) r_status <= 1'b0;
      end
   end

   assign irq = {2'b00, r_status & r_ctrl[CTRL_IRQ_EN]};

endmodule

// File: tb/tb_wb_timer_irq.sv
module tb_wb_timer_irq;
   import wb_timer_pkg::*;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] la_data_in;
   logic [63:0] la_oenb;
   logic [2:0]  irq;
   int          tests = 0;
   int          failed = 0;
   int          cyc_cnt = 0;

   wb_timer_irq_if tb_if ();

   wb_timer_irq #(.BASE_ADDR(32'h3000_0000), .PRESCALE_W(16)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wbs_cyc_i  (tb_if.cyc),
      .wbs_stb_i  (tb_if.stb),
      .wbs_we_i   (tb_if.we),
      .wbs_sel_i  (tb_if.sel),
      .wbs_adr_i  (tb_if.adr),
      .wbs_dat_i  (tb_if.dat_w),
      .wbs_ack_o  (tb_if.ack),
      .wbs_dat_o  (tb_if.dat_r),
      .la_data_in (la_data_in),
      .la_oenb    (la_oenb),
      .irq        (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Timer behaviour in terms of ticks: each tick compares, then counts
   // up or reloads.
   function automatic void model_run(input int ticks, input logic [31:0] start,
                                     input logic [31:0] cmp, input bit ar,
                                     output logic [31:0] cnt, output bit match);
      cnt = start;
      match = 0;
      for (int t = 0; t < ticks; t++) begin
         if (cnt == cmp) begin
            match = 1;
            cnt = ar ? 32'd0 : cnt + 32'd1;
         end else begin
            cnt = cnt + 32'd1;
         end
      end
   endfunction

   // Ticks land on edges E+k*(P+1), k>=1, after enable committed at edge E.
   function automatic int ticks_upto(input int e_en, input int last_edge, input int p);
      if (last_edge <= e_en) return 0;
      return (last_edge - e_en) / (p + 1);
   endfunction

   task automatic bus_idle();
      tb_if.cyc = 0; tb_if.stb = 0; tb_if.we = 0; tb_if.sel = 4'h0;
      tb_if.adr = '0; tb_if.dat_w = '0;
   endtask

   // Called at #1 after an edge; returns at #1 after the ack edge.
   task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdata, output int edge_n);
      tb_if.cyc = 1; tb_if.stb = 1; tb_if.we = we; tb_if.sel = sel;
      tb_if.adr = adr; tb_if.dat_w = dat;
      rdata = '0;
      edge_n = -1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (tb_if.ack === 1'b1) begin
            rdata = tb_if.dat_r;
            edge_n = cyc_cnt;
            break;
         end
      end
      bus_idle();
      if (edge_n < 0) begin
         tests++; failed++;
         $display("FAIL xfer_timeout adr=%h: got no ack, required ack within 8 cycles", adr);
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] dat, output int edge_n);
      logic [31:0] d;
      xfer(1'b1, BASE + {24'd0, off}, dat, 4'hF, d, edge_n);
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] dat, output int edge_n);
      xfer(1'b0, BASE + {24'd0, off}, 32'd0, 4'hF, dat, edge_n);
   endtask

   task automatic wait_until(input int target);
      while (cyc_cnt < target) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic check_all_zero(input string tag);
      logic [31:0] d;
      int e;
      logic [7:0] offs [5];
      offs = '{OFF_CTRL, OFF_PRESCALE, OFF_COUNT, OFF_COMPARE, OFF_STATUS};
      for (int i = 0; i < 5; i++) begin
         rd(offs[i], d, e);
         tests++;
         if (d !== 32'd0) begin
            failed++;
            $display("FAIL %s_reg_%02h got %h required 00000000", tag, offs[i], d);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (tb_if.ack !== 1'b0 || tb_if.dat_r !== 32'd0 || irq !== 3'b000) begin
         failed++;
         $display("FAIL reset_outputs got ack=%b dat=%h irq=%b required 0/0/0",
                  tb_if.ack, tb_if.dat_r, irq);
      end
      check_all_zero("reset");
      $display("[TB] test_reset done");
   endtask

   task automatic test_regs();
      logic [31:0] d, v, cmp_model;
      logic [3:0]  s;
      int e;
      do_reset();
      cmp_model = '0;
      for (int i = 0; i < 6; i++) begin
         v = $urandom;
         s = 4'($urandom_range(0, 15));
         xfer(1'b1, BASE + 32'h0C, v, s, d, e);
         for (int b = 0; b < 4; b++) if (s[b]) cmp_model[8*b +: 8] = v[8*b +: 8];
         rd(OFF_COMPARE, d, e);
         tests++;
         if (d !== cmp_model) begin
            failed++;
            $display("FAIL regs_compare_sel sel=%b got %h required %h", s, d, cmp_model);
         end
         $display("[TB] compare write %h sel=%b -> %h", v, s, d);
      end
      v = $urandom;
      wr(OFF_PRESCALE, v, e);
      rd(OFF_PRESCALE, d, e);
      tests++;
      if (d !== (v & 32'h0000_FFFF)) begin
         failed++;
         $display("FAIL regs_prescale got %h required %h", d, v & 32'h0000_FFFF);
      end
      v = $urandom & 32'hFFFF_FFFE;
      wr(OFF_CTRL, v, e);
      rd(OFF_CTRL, d, e);
      tests++;
      if (d !== (v & 32'h6)) begin
         failed++;
         $display("FAIL regs_ctrl got %h required %h", d, v & 32'h6);
      end
      wr(OFF_CTRL, 32'd0, e);
      wr(8'h18, 32'hDEAD_BEEF, e);
      rd(8'h18, d, e);
      tests++;
      if (d !== 32'd0) begin
         failed++;
         $display("FAIL regs_unmapped got %h required 00000000", d);
      end
   endtask

   task automatic test_sel();
      logic [31:0] d;
      int e;
      do_reset();
      xfer(1'b1, BASE + 32'h0C, 32'hAABB_CCDD, 4'b0010, d, e);
      rd(OFF_COMPARE, d, e);
      tests++;
      if (d !== 32'h0000_CC00) begin
         failed++;
         $display("FAIL sel_compare got %h required 0000cc00", d);
      end
      $display("[TB] sel 0010 write -> compare %h", d);
   endtask

   task automatic test_window();
      logic [31:0] d;
      int e, acks;
      rd(8'h14, d, e);
      tests++;
      if (d !== 32'd0) begin
         failed++;
         $display("FAIL window_0x14_data got %h required 00000000", d);
      end
      tests++;
      if (tb_if.ack !== 1'b1) begin
         failed++;
         $display("FAIL window_0x14_ack got %b required 1", tb_if.ack);
      end
      @(posedge clk); #1;
      tests++;
      if (tb_if.ack !== 1'b0) begin
         failed++;
         $display("FAIL window_ack_width got %b required 0", tb_if.ack);
      end
      tb_if.cyc = 1; tb_if.stb = 1; tb_if.we = 1; tb_if.sel = 4'hF;
      tb_if.adr = 32'h3000_010C; tb_if.dat_w = 32'h1234_5678;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (tb_if.ack === 1'b1) acks++;
      end
      bus_idle();
      tests++;
      if (acks != 0) begin
         failed++;
         $display("FAIL window_outside_ack got %0d acks required 0", acks);
      end
      rd(OFF_COMPARE, d, e);
      tests++;
      if (d !== 32'h0000_CC00) begin
         failed++;
         $display("FAIL window_outside_write got compare %h required 0000cc00", d);
      end
      $display("[TB] outside window: %0d acks", acks);
   endtask

   task automatic test_irq_match();
      logic [31:0] d;
      int e, e_en;
      bit hit;
      do_reset();
      wr(OFF_PRESCALE, 32'd3, e);
      wr(OFF_COMPARE, 32'd5, e);
      wr(OFF_CTRL, 32'd7, e_en);
      hit = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (irq[0] === 1'b1) begin hit = 1; break; end
      end
      tests++;
      if (!hit || (cyc_cnt - e_en) != 24) begin
         failed++;
         $display("FAIL irq_rise_cycles got %0d (seen=%0d) required 24", cyc_cnt - e_en, hit);
      end
      rd(OFF_COUNT, d, e);
      tests++;
      if (d !== 32'd0) begin
         failed++;
         $display("FAIL irq_count_reload got %h required 00000000", d);
      end
      $display("[TB] irq rose after %0d cycles, count %h", cyc_cnt - e_en, d);
   endtask

   task automatic test_wrap();
      logic [31:0] d, exp_cnt;
      bit m;
      int e, e_en, w;
      do_reset();
      wr(OFF_PRESCALE, 32'd0, e);
      wr(OFF_COUNT, 32'hFFFF_FFFF, e);
      wr(OFF_CTRL, 32'd1, e_en);
      for (int k = 0; k < 2; k++) begin
         rd(OFF_COUNT, d, e);
         model_run(ticks_upto(e_en, e - 1, 0), 32'hFFFF_FFFF, 32'd0, 1'b0, exp_cnt, m);
         tests++;
         if (d !== exp_cnt) begin
            failed++;
            $display("FAIL wrap_count_%0d got %h required %h", k, d, exp_cnt);
         end
         $display("[TB] wrap read %0d count %h", k, d);
      end
      wr(OFF_CTRL, 32'd0, e);
      wr(OFF_PRESCALE, 32'd3, e);
      wr(OFF_CTRL, 32'd1, e_en);
      wait_until(e_en + 7);
      wr(OFF_COUNT, 32'h10, w);
      tests++;
      if (w != e_en + 8) begin
         failed++;
         $display("FAIL wrap_write_edge got %0d required %0d", w - e_en, 8);
      end
      rd(OFF_COUNT, d, e);
      tests++;
      if (d !== 32'h10) begin
         failed++;
         $display("FAIL wrap_write_priority got %h required 00000010", d);
      end
      $display("[TB] count write on tick -> %h", d);
   endtask

   task automatic test_match_clear();
      logic [31:0] d;
      int e, e_en, w;
      bit hit;
      do_reset();
      wr(OFF_PRESCALE, 32'd3, e);
      wr(OFF_COMPARE, 32'd1, e);
      wr(OFF_CTRL, 32'd7, e_en);
      // Matches at E+8, E+16, E+24 (autoreload between them).
      wait_until(e_en + 15);
      wr(OFF_STATUS, 32'd1, w);
      tests++;
      if (w != e_en + 16 || irq !== 3'b001) begin
         failed++;
         $display("FAIL clear_vs_match_irq got edge %0d irq=%b required edge 16 irq=001", w - e_en, irq);
      end
      rd(OFF_STATUS, d, e);
      tests++;
      if (d !== 32'd1) begin
         failed++;
         $display("FAIL clear_vs_match_status got %h required 00000001", d);
      end
      wait_until(e_en + 18);
      wr(OFF_STATUS, 32'd1, w);
      tests++;
      if (irq !== 3'b000) begin
         failed++;
         $display("FAIL clear_irq got %b required 000", irq);
      end
      rd(OFF_STATUS, d, e);
      tests++;
      if (d !== 32'd0) begin
         failed++;
         $display("FAIL clear_status got %h required 00000000", d);
      end
      hit = 0;
      for (int i = 0; i < 20; i++) begin
         if (irq[0] === 1'b1) begin hit = 1; break; end
         @(posedge clk); #1;
      end
      tests++;
      if (!hit || cyc_cnt != e_en + 24) begin
         failed++;
         $display("FAIL rematch_edge got %0d (seen=%0d) required 24", cyc_cnt - e_en, hit);
      end
      $display("[TB] w1c vs match done, rematch at +%0d", cyc_cnt - e_en);
   endtask

   task automatic test_back_to_back();
      logic [31:0] v, d;
      int e, acks, consec, bad_dat, bad_val;
      bit prev;
      do_reset();
      v = $urandom;
      wr(OFF_COMPARE, v, e);
      @(posedge clk); #1;
      tb_if.cyc = 1; tb_if.stb = 1; tb_if.we = 0; tb_if.sel = 4'hF;
      tb_if.adr = BASE + 32'h0C;
      acks = 0; consec = 0; bad_dat = 0; bad_val = 0; prev = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (tb_if.ack === 1'b1) begin
            acks++;
            if (prev) consec++;
            if (tb_if.dat_r !== v) bad_val++;
            prev = 1;
         end else begin
            if (tb_if.dat_r !== 32'd0) bad_dat++;
            prev = 0;
         end
      end
      bus_idle();
      tests++;
      if (acks != 6) begin
         failed++;
         $display("FAIL b2b_ack_count got %0d required 6", acks);
      end
      tests++;
      if (consec != 0) begin
         failed++;
         $display("FAIL b2b_consecutive got %0d required 0", consec);
      end
      tests++;
      if (bad_dat != 0 || bad_val != 0) begin
         failed++;
         $display("FAIL b2b_data got %0d nonzero-idle %0d wrong-value required 0 0", bad_dat, bad_val);
      end
      $display("[TB] back-to-back: %0d acks in 12 cycles", acks);
      d = '0;
   endtask

   task automatic test_reset_mid();
      int e, e_en;
      bit got_ack;
      do_reset();
      wr(OFF_PRESCALE, 32'd0, e);
      wr(OFF_COMPARE, 32'd0, e);
      wr(OFF_CTRL, 32'd3, e_en);
      @(posedge clk); #1;
      tb_if.cyc = 1; tb_if.stb = 1; tb_if.we = 0; tb_if.sel = 4'hF;
      tb_if.adr = BASE + 32'h08;
      got_ack = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (tb_if.ack === 1'b1) begin got_ack = 1; break; end
      end
      tests++;
      if (!got_ack || irq !== 3'b001) begin
         failed++;
         $display("FAIL midreset_pre got ack=%0d irq=%b required 1 001", got_ack, irq);
      end
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         tests++;
         if (tb_if.ack !== 1'b0 || tb_if.dat_r !== 32'd0 || irq !== 3'b000) begin
            failed++;
            $display("FAIL midreset_outputs_%0d got ack=%b dat=%h irq=%b required 0/0/000",
                     i, tb_if.ack, tb_if.dat_r, irq);
         end
      end
      bus_idle();
      rst = 0;
      check_all_zero("midreset");
      $display("[TB] reset during ACK done");
   endtask

   task automatic test_random();
      logic [31:0] d, cmp, exp_cnt;
      int e, e_en, s1, s2, p;
      bit ar, ie, m;
      for (int it = 0; it < 6; it++) begin
         do_reset();
         p   = $urandom_range(0, 4);
         cmp = 32'($urandom_range(0, 12));
         ar  = 1'($urandom_range(0, 1));
         ie  = 1'($urandom_range(0, 1));
         wr(OFF_PRESCALE, p, e);
         wr(OFF_COMPARE, cmp, e);
         wr(OFF_CTRL, {29'd0, ar, ie, 1'b1}, e_en);
         repeat ($urandom_range(0, 40)) begin @(posedge clk); #1; end
         rd(OFF_COUNT, d, s1);
         model_run(ticks_upto(e_en, s1 - 1, p), 32'd0, cmp, ar, exp_cnt, m);
         tests++;
         if (d !== exp_cnt) begin
            failed++;
            $display("FAIL rand_count it=%0d got %h required %h", it, d, exp_cnt);
         end
         rd(OFF_STATUS, d, s2);
         model_run(ticks_upto(e_en, s2 - 1, p), 32'd0, cmp, ar, exp_cnt, m);
         tests++;
         if (d !== {31'd0, m}) begin
            failed++;
            $display("FAIL rand_status it=%0d got %h required %0d", it, d, m);
         end
         model_run(ticks_upto(e_en, s2, p), 32'd0, cmp, ar, exp_cnt, m);
         tests++;
         if (irq !== {2'b00, m & ie}) begin
            failed++;
            $display("FAIL rand_irq it=%0d got %b required %b", it, irq, {2'b00, m & ie});
         end
         $display("[TB] random it=%0d p=%0d cmp=%0d ar=%0d ie=%0d ticks=%0d", it, p, cmp, ar, ie,
                  ticks_upto(e_en, s2, p));
      end
   endtask

   initial begin
      la_data_in = {$urandom, $urandom};
      la_oenb    = '1;
      bus_idle();
      rst = 1;
      test_reset();
      test_regs();
      test_sel();
      test_window();
      test_irq_match();
      test_wrap();
      test_match_clear();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
